// File: rtl/ps2_scan_decoder_if.sv
// Byte-stream input from the PS/2 controller and the decoded event/status side.
// The decoder connects to the slave modport and the environment to the master modport.
interface ps2_scan_decoder_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       tx_rqst;

  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       ev_pause;

  logic       sts_ack;
  logic       sts_resend;
  logic       sts_bat_ok;
  logic       sts_bat_fail;
  logic       sts_ovr;
  logic       sts_err;

  logic       ovf;
  logic       ovf_clr;

  modport master (
    output rx_valid, rx_data, rx_err, tx_rqst, ev_ready, ovf_clr,
    input  ev_valid, ev_code, ev_ext, ev_brk, ev_pause,
    input  sts_ack, sts_resend, sts_bat_ok, sts_bat_fail, sts_ovr, sts_err, ovf
  );

  modport slave (
    input  rx_valid, rx_data, rx_err, tx_rqst, ev_ready, ovf_clr,
    output ev_valid, ev_code, ev_ext, ev_brk, ev_pause,
    output sts_ack, sts_resend, sts_bat_ok, sts_bat_fail, sts_ovr, sts_err, ovf
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Folds Scan Code Set 2 prefix sequences into single key events queued in a small FIFO;
// device status bytes are reported as one-cycle pulses.
module ps2_scan_decoder #(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  ps2_scan_decoder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic        rx_valid_q;
  logic        rx_edge, acc, err_stb;

  logic        push;
  logic [10:0] push_entry;

  logic ack_d, resend_d, bat_ok_d, bat_fail_d, ovr_d, err_d;
  logic ack_q, resend_q, bat_ok_q, bat_fail_q, ovr_q, err_q;

  logic [AW:0]  wptr_q, rptr_q;
  logic [10:0]  mem_q [DEPTH];
  logic [10:0]  head;
  logic         full, empty, pop, wr_en, drop;
  logic         ovf_q;

  // Edge-detect valid so a level-held valid (error state, post-TX) counts once.
  assign rx_edge = bus.rx_valid & ~rx_valid_q;
  assign acc     = rx_edge & ~bus.tx_rqst & ~bus.rx_err;
  assign err_stb = rx_edge & bus.rx_err;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    push       = 1'b0;
    push_entry = '0;
    ack_d      = 1'b0;
    resend_d   = 1'b0;
    bat_ok_d   = 1'b0;
    bat_fail_d = 1'b0;
    ovr_d      = 1'b0;
    err_d      = 1'b0;

    if (err_stb) begin
      err_d   = 1'b1;
      state_d = StIdle;
      pcnt_d  = '0;
    end else if (acc) begin
      unique case (state_q)
        StIdle: begin
          case (bus.rx_data)
            8'hE0: state_d = StExt;
            8'hF0: state_d = StBrk;
            8'hE1: begin
              state_d = StPause;
              pcnt_d  = '0;
            end
            8'hFA: ack_d = 1'b1;
            8'hFE: resend_d = 1'b1;
            8'hAA: bat_ok_d = 1'b1;
            8'hFC, 8'hFD: bat_fail_d = 1'b1;
            8'h00, 8'hFF: ovr_d = 1'b1;
            default: begin
              push       = 1'b1;
              push_entry = {3'b000, bus.rx_data};
            end
          endcase
        end
        StExt: begin
          case (bus.rx_data)
            8'hF0: state_d = StExtBrk;
            8'hE0: state_d = StExt;
            8'hE1: begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
            default: begin
              push       = 1'b1;
              push_entry = {3'b010, bus.rx_data};
              state_d    = StIdle;
            end
          endcase
        end
        StBrk, StExtBrk: begin
          case (bus.rx_data)
            8'hE0, 8'hE1, 8'hF0: begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
            default: begin
              push       = 1'b1;
              push_entry = {1'b0, state_q == StExtBrk, 1'b1, bus.rx_data};
              state_d    = StIdle;
            end
          endcase
        end
        StPause: begin
          // Pause payload is not inspected; the 7th byte after E1 completes it.
          pcnt_d = pcnt_q + 3'd1;
          if (pcnt_q == 3'd6) begin
            push       = 1'b1;
            push_entry = {3'b100, 8'hE1};
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pcnt_q     <= '0;
      rx_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      resend_q   <= 1'b0;
      bat_ok_q   <= 1'b0;
      bat_fail_q <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      rx_valid_q <= bus.rx_valid;
      ack_q      <= ack_d;
      resend_q   <= resend_d;
      bat_ok_q   <= bat_ok_d;
      bat_fail_q <= bat_fail_d;
      ovr_q      <= ovr_d;
      err_q      <= err_d;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & bus.ev_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wptr_q[AW-1:0]] <= push_entry;
        wptr_q                <= wptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign head         = mem_q[rptr_q[AW-1:0]];
  assign bus.ev_valid = ~empty;
  assign bus.ev_code  = head[7:0];
  assign bus.ev_brk   = head[8];
  assign bus.ev_ext   = head[9];
  assign bus.ev_pause = head[10];

  assign bus.sts_ack      = ack_q;
  assign bus.sts_resend   = resend_q;
  assign bus.sts_bat_ok   = bat_ok_q;
  assign bus.sts_bat_fail = bat_fail_q;
  assign bus.sts_ovr      = ovr_q;
  assign bus.sts_err      = err_q;
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: a prefix-list reference model predicts events and
// status pulses; a negedge monitor pops and compares whatever the decoder presents.
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 4;

  localparam logic [5:0] SAck     = 6'b100000;
  localparam logic [5:0] SResend  = 6'b010000;
  localparam logic [5:0] SBatOk   = 6'b001000;
  localparam logic [5:0] SBatFail = 6'b000100;
  localparam logic [5:0] SOvr     = 6'b000010;
  localparam logic [5:0] SErr     = 6'b000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [10:0] evq  [$];
  logic [5:0]  stsq [$];
  logic [7:0]  pfx  [$];
  logic        exp_ovf = 1'b0;
  bit          pend_ev_v;
  bit          pend_drop;
  logic [10:0] pend_ev;
  logic [5:0]  pend_sts;
  int          rdy_mode = 0;
  int          rdy_pct  = 50;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic bit pfx_has(input logic [7:0] v);
    foreach (pfx[i]) if (pfx[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: keep the bytes seen since the last completed event and decide from them.
  task automatic model_byte(input logic [7:0] b, input logic err, input logic tx);
    pend_ev_v = 1'b0;
    pend_ev   = '0;
    pend_sts  = '0;
    pend_drop = 1'b0;
    if (err) begin
      pfx.delete();
      pend_sts = SErr;
    end else if (tx) begin
      // byte not accepted
    end else if (pfx.size() > 0 && pfx[0] == 8'hE1) begin
      pfx.push_back(b);
      if (pfx.size() == 8) begin
        pend_ev_v = 1'b1;
        pend_ev   = {3'b100, 8'hE1};
        pfx.delete();
      end
    end else if (pfx.size() == 0) begin
      case (b)
        8'hE0, 8'hF0, 8'hE1: pfx.push_back(b);
        8'hFA: pend_sts = SAck;
        8'hFE: pend_sts = SResend;
        8'hAA: pend_sts = SBatOk;
        8'hFC, 8'hFD: pend_sts = SBatFail;
        8'h00, 8'hFF: pend_sts = SOvr;
        default: begin
          pend_ev_v = 1'b1;
          pend_ev   = {3'b000, b};
        end
      endcase
    end else begin
      if (b == 8'hE1 || ((b == 8'hE0 || b == 8'hF0) && pfx_has(8'hF0))) begin
        pend_sts = SErr;
        pfx.delete();
      end else if (b == 8'hF0) begin
        pfx.push_back(b);
      end else if (b != 8'hE0) begin
        pend_ev_v = 1'b1;
        pend_ev   = {1'b0, pfx_has(8'hE0), pfx_has(8'hF0), b};
        pfx.delete();
      end
    end
    // evq now reflects occupancy after any pop on the coming edge.
    if (pend_ev_v && evq.size() >= DEPTH) pend_drop = 1'b1;
  endtask

  task automatic commit();
    if (pend_ev_v) begin
      if (pend_drop) exp_ovf = 1'b1;
      else evq.push_back(pend_ev);
    end
    if (pend_sts != '0) stsq.push_back(pend_sts);
    pend_ev_v = 1'b0;
    pend_sts  = '0;
  endtask

  task automatic send(input logic [7:0] b, input logic err, input logic tx);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.rx_err   = err;
    bus.tx_rqst  = tx;
    @(negedge clk); #1;
    model_byte(b, err, tx);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    bus.tx_rqst  = 1'b0;
    commit();
  endtask

  task automatic hold_byte(input logic [7:0] b, input int n);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk); #1;
    model_byte(b, 1'b0, 1'b0);
    @(posedge clk); #1;
    commit();
    repeat (n - 1) @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    evq.delete();
    stsq.delete();
    pfx.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("rst_ev_valid", bus.ev_valid, 0);
    chk("rst_ev_head", {bus.ev_pause, bus.ev_ext, bus.ev_brk, bus.ev_code}, 0);
    chk("rst_sts", {bus.sts_ack, bus.sts_resend, bus.sts_bat_ok, bus.sts_bat_fail,
                    bus.sts_ovr, bus.sts_err}, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 4 * DEPTH + 8; i++) begin
      @(negedge clk); #1;
      if (evq.size() == 0 && !bus.ev_valid) break;
    end
    chk("drain_empty", bus.ev_valid, 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.ev_ready = 1'b0;
      1:       bus.ev_ready = 1'b1;
      default: bus.ev_ready = ($urandom_range(0, 99) < rdy_pct);
    endcase
  end

  // Monitor: status pulses must appear exactly in the cycle after the byte.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [5:0]  s_got, s_exp;
    if (rst_n) begin
      chk("ev_valid", bus.ev_valid, evq.size() != 0);
      chk("ovf", bus.ovf, exp_ovf);
      if (bus.ev_valid && bus.ev_ready) begin
        if (evq.size() == 0) begin
          chk("ev_unexpected", {bus.ev_pause, bus.ev_ext, bus.ev_brk, bus.ev_code}, 32'hFFFF);
        end else begin
          e = evq.pop_front();
          chk("ev_head", {bus.ev_pause, bus.ev_ext, bus.ev_brk, bus.ev_code}, e);
        end
      end
      s_got = {bus.sts_ack, bus.sts_resend, bus.sts_bat_ok, bus.sts_bat_fail,
               bus.sts_ovr, bus.sts_err};
      s_exp = (stsq.size() != 0) ? stsq.pop_front() : 6'b0;
      if (s_got != 6'b0 || s_exp != 6'b0) chk("sts", s_got, s_exp);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.rx_err   = 1'b0;
    bus.tx_rqst  = 1'b0;
    bus.ovf_clr  = 1'b0;
    pend_ev_v    = 1'b0;
    pend_sts     = '0;
    do_reset();

    // Make/break, extended, doubled E0.
    rdy_mode = 0;
    send(8'h1C, 0, 0);
    chk("make_visible", bus.ev_valid, 1);
    send(8'hF0, 0, 0); send(8'h1C, 0, 0);
    send(8'hE0, 0, 0); send(8'h75, 0, 0);
    drain();
    send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
    send(8'hE0, 0, 0); send(8'hE0, 0, 0); send(8'h75, 0, 0);
    drain();

    // Pause sequence: nothing until the 8th byte.
    rdy_mode = 0;
    send(8'hE1, 0, 0); send(8'h14, 0, 0); send(8'h77, 0, 0); send(8'hE1, 0, 0);
    send(8'hF0, 0, 0); send(8'h14, 0, 0); send(8'hF0, 0, 0);
    @(negedge clk);
    chk("pause_not_early", bus.ev_valid, 0);
    send(8'h77, 0, 0);
    @(negedge clk);
    chk("pause_head", {bus.ev_pause, bus.ev_ext, bus.ev_brk, bus.ev_code}, {3'b100, 8'hE1});
    drain();

    // Status bytes in IDLE.
    send(8'hFA, 0, 0); send(8'hFE, 0, 0); send(8'hAA, 0, 0); send(8'hFC, 0, 0);
    send(8'h00, 0, 0); send(8'hFD, 0, 0); send(8'hFF, 0, 0);
    // Status byte after a prefix is an ordinary code.
    send(8'hE0, 0, 0); send(8'hFA, 0, 0);
    drain();

    // Overflow: DEPTH+1 makes with ready low, then push-while-full with pop, then clear.
    rdy_mode = 0;
    send(8'h15, 0, 0); send(8'h16, 0, 0); send(8'h1D, 0, 0); send(8'h22, 0, 0);
    send(8'h23, 0, 0);
    chk("ovf_set", bus.ovf, 1);
    rdy_mode = 1;
    send(8'h24, 0, 0);
    drain();
    chk("ovf_sticky", bus.ovf, 1);
    @(posedge clk); #1 bus.ovf_clr = 1'b1;
    @(posedge clk); #1 bus.ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clr", bus.ovf, 0);

    // Error strobe mid-sequence, error during TX, protocol errors.
    send(8'hF0, 1, 0); send(8'h1C, 0, 0);
    send(8'hE0, 0, 0); send(8'h55, 1, 1); send(8'h1C, 0, 0);
    send(8'hF0, 0, 0); send(8'hE0, 0, 0);
    send(8'hE0, 0, 0); send(8'hE1, 0, 0);
    drain();

    // Level-held valid counts once.
    hold_byte(8'h2B, 20);
    drain();

    // TX request blocks acceptance; the post-TX held valid never accepts.
    rdy_mode = 0;
    @(posedge clk); #1;
    bus.tx_rqst  = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h1C;
    repeat (5) @(posedge clk);
    #1 bus.tx_rqst = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("tx_no_event", bus.ev_valid, 0);

    // Reset after E0: next byte decodes from IDLE.
    send(8'hE0, 0, 0);
    do_reset();
    rdy_mode = 0;
    send(8'h1C, 0, 0);
    @(negedge clk);
    chk("post_rst_make", {bus.ev_pause, bus.ev_ext, bus.ev_brk, bus.ev_code}, {3'b000, 8'h1C});
    drain();

    // Randomised stream against the model.
    rdy_mode = 2;
    for (int n = 0; n < 1200; n++) begin
      if (n % 200 == 0) rdy_pct = $urandom_range(10, 95);
      r = $urandom_range(0, 19);
      if (r < 3)       b = 8'hE0;
      else if (r < 5)  b = 8'hF0;
      else if (r == 5) b = 8'hE1;
      else             b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(b, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Downstream of the PS/2 controller in the keyboard path. Consumes received bytes (Scan Code Set 2) and folds prefix sequences (E0, F0, E0 F0, the 8-byte E1 Pause sequence) into single key events. Events go into a small FIFO with a ready/valid output. Device status bytes (ACK, RESEND, BAT, overrun) are reported as one-cycle pulses and are not queued.

## Interface
- DEPTH, 4: event FIFO entries; power of two, ≥2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  controller valid. Pulses for 1 cycle on a good byte. Stays high in the controller's error state and after a TX.
- rx_data  in  8  controller received byte.
- rx_err  in  1  OR of the controller flags. Qualifies rx_valid.
- tx_rqst  in  1  TX request driven to the controller. While high, rx_valid is ignored.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer pops the head when ev_valid & ev_ready.
- ev_code  out  8  head event scan code.
- ev_ext  out  1  head event had an E0 prefix.
- ev_brk  out  1  head event is a release (F0).
- ev_pause  out  1  head event is Pause. ev_code = 8'hE1, ext = 0, brk = 0.
- sts_ack, sts_resend, sts_bat_ok, sts_bat_fail, sts_ovr  out  1 each  one-cycle pulses.
- sts_err  out  1  one-cycle pulse on a protocol or link error.
- ovf  out  1  sticky; an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf. If a drop occurs in the same cycle, ovf stays set.

## Operation
- Accept strobe: acc = rx_valid & ~rx_valid_q & ~tx_rqst & ~rx_err.
  - rx_valid_q is rx_valid registered (reset 0).
  - The strobe is edge-based so a level-held valid is counted once.
- Error strobe: rx_valid & ~rx_valid_q & rx_err. Effect:
  - sts_err pulse.
  - FSM forced to IDLE; the pause counter is cleared.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Reset state is IDLE. It changes only on acc or the error strobe.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE, pcnt = 0.
  - FA, FE, AA → sts_ack, sts_resend, sts_bat_ok respectively.
  - FC, FD → sts_bat_fail.
  - 00, FF → sts_ovr.
  - Any other byte → push {code, ext 0, brk 0}.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay in EXT.
  - E1 → sts_err, IDLE.
  - Any other byte → push {code, ext 1, brk 0}, IDLE.
- BRK:
  - E0, E1, F0 → sts_err, IDLE.
  - Any other byte → push {code, ext 0, brk 1}, IDLE.
- EXT_BRK:
  - E0, E1, F0 → sts_err, IDLE.
  - Any other byte → push {code, ext 1, brk 1}, IDLE.
- PAUSE:
  - Each accepted byte increments the 3-bit pcnt. Content is not checked.
  - On the 7th byte after E1 (pcnt == 6 when the byte arrives) → push the pause event, IDLE.
- Status bytes are decoded only in IDLE. In other states they are ordinary codes.
- FIFO:
  - 11-bit entries {pause, ext, brk, code}.
  - Read and write pointers of log2(DEPTH)+1 bits; they wrap naturally.
  - full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- Push while full:
  - If ev_ready & ev_valid in the same cycle, the pop frees space and the push succeeds.
  - Otherwise the event is dropped and ovf is set.
- Push while empty: ev_valid rises the next cycle; pop is impossible that cycle.

## Timing
- Reset values:
  - All sts_* = 0, ovf = 0, ev_valid = 0.
  - ev_* = 0 (head of a cleared FIFO; the storage array is reset).
  - pcnt = 0, rx_valid_q = 0, state IDLE.
- Acceptance: cycle N is the first cycle with rx_valid = 1.
  - State update and FIFO write occur on the edge ending cycle N.
  - ev_valid and sts_* are visible in cycle N+1.
  - sts_* are registered and high for exactly one cycle.
- Pop: on the edge where ev_valid & ev_ready. The next head, or ev_valid = 0, is visible in the following cycle. The outputs are the head entry (registered memory read, zero added latency).
- Throughput: 1 push and 1 pop per cycle.
- rst_n asserted mid-sequence (e.g. after E0): state, FIFO and flags clear asynchronously. The following byte is decoded from IDLE.
- tx_rqst high: bytes are not accepted. The error strobe is still honoured. The level-held rx_valid after TX completion never produces acc.

## Test plan
- Bytes 1C, F0 1C → events {1C, e0 b0}, {1C, e0 b1}. ev_valid one cycle after each final byte.
- E0 75, E0 F0 75 → {75, ext 1, brk 0}, {75, ext 1, brk 1}. E0 E0 75 → {75, ext 1}.
- E1 14 77 E1 F0 14 F0 77 → exactly one event, pause = 1, code E1. The FIFO must be empty after the first 7 bytes.
- FA, FE, AA, FC, 00 in IDLE → one pulse each on ack, resend, bat_ok, bat_fail, ovr. No events.
- ev_ready held low, DEPTH+1 make codes:
  - First DEPTH are retained in order; the last is dropped; ovf = 1.
  - Then push-while-full with ev_ready = 1 → no drop.
  - ovf_clr → ovf = 0.
- Edge cases:
  - F0 with rx_err = 1 → sts_err; the next 1C decodes as a make.
  - rx_valid held high 20 cycles → one event.
  - tx_rqst = 1 with valid → nothing.
  - rst_n low after E0, then 1C → make with ext = 0.
